// File: rtl/serial_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// serial_rx_fifo_if
// Groups the UART-side receive handshake and the host-side read port of
// serial_rx_fifo into one bundle.
//   master : the environment (UART receiver + host consumer)
//   slave  : the serial_rx_fifo block itself
// Signals:
//   rx_dat[7:0]   received byte, valid while rx_ready is high
//   rx_ready      byte-available level from the receiver
//   ready_rst     one-cycle acknowledge back to the receiver
//   rd_en         host read request
//   dout[7:0]     registered read data
//   dout_vld      one-cycle strobe, dout updated this cycle
//   empty / full  occupancy flags
//   count         occupancy 0..2^DEPTH_LOG2
//   overflow      sticky drop flag
//   ovf_clr       clears overflow
// ---------------------------------------------------------------------------
interface serial_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
) ();

    logic [7:0]            rx_dat;
    logic                  rx_ready;
    logic                  ready_rst;
    logic                  rd_en;
    logic [7:0]            dout;
    logic                  dout_vld;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  ovf_clr;

    modport master (
        output rx_dat,
        output rx_ready,
        input  ready_rst,
        output rd_en,
        input  dout,
        input  dout_vld,
        input  empty,
        input  full,
        input  count,
        input  overflow,
        output ovf_clr
    );

    modport slave (
        input  rx_dat,
        input  rx_ready,
        output ready_rst,
        input  rd_en,
        output dout,
        output dout_vld,
        output empty,
        output full,
        output count,
        output overflow,
        input  ovf_clr
    );

endinterface

// File: rtl/serial_rx_fifo.sv
// ---------------------------------------------------------------------------
// serial_rx_fifo
// Receive-side byte buffer placed right after the UART receiver. Every byte
// announced by rx_ready is acknowledged with a single ready_rst pulse so the
// receiver never stalls; the byte is stored in a 2^DEPTH_LOG2-entry FIFO, or
// dropped (and overflow raised) when the FIFO is full and no read frees a
// slot on the same edge. The host drains the FIFO with rd_en.
// Ports:
//   clk    system clock (same domain as the UART receiver)
//   rst_n  asynchronous active-low reset
//   bus    serial_rx_fifo_if.slave (rx handshake, read port, status flags)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module serial_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_rx_fifo_if.slave       bus
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ZERO_C = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE_C  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO_C = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C  = CNT_ONE_C[DEPTH_LOG2-1:0];

    // Acknowledge handshake states toward the UART receiver.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;

    logic [7:0]             mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_r;
    logic [DEPTH_LOG2-1:0]  rd_ptr_r;
    logic [DEPTH_LOG2:0]    count_r;
    logic [DEPTH_LOG2:0]    count_nxt_s;

    logic                   wr_try_s;
    logic                   wr_acc_s;
    logic                   rd_acc_s;
    logic                   drop_s;

    logic [7:0]             dout_r;
    logic                   dout_vld_r;
    logic                   ready_rst_r;
    logic                   overflow_r;
    logic                   empty_r;
    logic                   full_r;

    // Handshake FSM next-state: a byte is taken exactly once, on leaving IDLE.
    always_comb begin
        state_nxt_s = state_r;
        wr_try_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.rx_ready) begin
                    state_nxt_s = ST_ACK;
                    wr_try_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                // Hold off until the receiver has dropped rx_ready, otherwise
                // the same byte would be seen again.
                if (!bus.rx_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Read/write acceptance and next occupancy.
    always_comb begin
        rd_acc_s    = 1'b0;
        wr_acc_s    = 1'b0;
        drop_s      = 1'b0;
        count_nxt_s = count_r;

        if (bus.rd_en && (count_r != CNT_ZERO_C)) begin
            rd_acc_s = 1'b1;
        end else begin
            rd_acc_s = 1'b0;
        end

        // A full FIFO still takes the byte if a read frees the slot on the
        // same edge; the read sees the old entry because memory updates are
        // non-blocking.
        if (wr_try_s && ((count_r < DEPTH_C) || rd_acc_s)) begin
            wr_acc_s = 1'b1;
            drop_s   = 1'b0;
        end else if (wr_try_s) begin
            wr_acc_s = 1'b0;
            drop_s   = 1'b1;
        end else begin
            wr_acc_s = 1'b0;
            drop_s   = 1'b0;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pointers, occupancy and the flags decoded from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO_C;
            rd_ptr_r <= PTR_ZERO_C;
            count_r  <= CNT_ZERO_C;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CNT_ZERO_C);
            full_r  <= (count_nxt_s == DEPTH_C);
        end
    end

    // Byte storage; contents after reset are don't-care, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.rx_dat;
        end
    end

    // Read data, strobes, acknowledge pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r      <= 8'h00;
            dout_vld_r  <= 1'b0;
            ready_rst_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (rd_acc_s) begin
                dout_r <= mem_r[rd_ptr_r];
            end
            dout_vld_r  <= rd_acc_s;
            // Ack is issued whether the byte was stored or dropped.
            ready_rst_r <= wr_try_s;
            // A drop on the same edge as a clear keeps the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign bus.ready_rst = ready_rst_r;
    assign bus.dout      = dout_r;
    assign bus.dout_vld  = dout_vld_r;
    assign bus.empty     = empty_r;
    assign bus.full      = full_r;
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: doc/serial_rx_fifo.md
# serial_rx_fifo

Receive-side buffer that sits directly downstream of the `serial` UART receiver. It acknowledges each received byte using the receiver's `ready`/`ready_rst` handshake, which frees the receiver for the next character. Each byte is stored in a power-of-two FIFO that the host logic drains at its own pace. Bytes that arrive while the FIFO is full are dropped and flagged, so the UART never stalls.

## Interface
- `DEPTH_LOG2`, 4: log2 of FIFO depth; depth D = 2^DEPTH_LOG2 (default 16 entries).
- `clk`  in  1  system clock, same domain as `serial` (50 MHz in the bench).
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_dat`  in  8  received byte from `serial`; valid while `rx_ready`=1.
- `rx_ready`  in  1  level from `serial`; high from byte completion until acknowledged.
- `ready_rst`  out  1  one-cycle acknowledge pulse to `serial`.
- `rd_en`  in  1  consumer read request.
- `dout`  out  8  read data, registered.
- `dout_vld`  out  1  one-cycle strobe: `dout` updated this cycle.
- `empty`  out  1  count == 0.
- `full`  out  1  count == D.
- `count`  out  DEPTH_LOG2+1  current occupancy, 0..D.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Storage: D×8 memory, write and read pointers of DEPTH_LOG2 bits each. Pointers wrap modulo D naturally; no special case at D-1 → 0.
- Ack FSM, three states:
  - IDLE: if `rx_ready`=1, capture `rx_dat` as a write attempt and go to ACK.
  - ACK: drive `ready_rst`=1 for exactly this cycle, then go to WAIT.
  - WAIT: stay until `rx_ready`=0, then go to IDLE. This prevents the same byte being written twice.
- Write attempt (the IDLE→ACK edge):
  - Accepted if count < D, or if a read is accepted on the same edge.
  - Otherwise the byte is dropped and `overflow` is set.
  - The ack is issued in either case.
- Read: accepted when `rd_en`=1 and count > 0. An accepted read sets `dout` = mem[rd_ptr], advances `rd_ptr`, and pulses `dout_vld`.
  - `rd_en` while empty is ignored. `dout` holds its value and there is no `dout_vld`.
  - There is no write-to-read bypass: a simultaneous write into an empty FIFO plus `rd_en` accepts the write and ignores the read.
- Count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when a write and a read are both accepted on the same edge.
- `overflow`:
  - Set by a dropped write.
  - Cleared by `ovf_clr`.
  - If a drop and `ovf_clr` occur on the same edge, set wins.
- `empty` and `full` are derived from registered `count`.

## Timing
- Reset (`rst_n`=0, asynchronous) sets the following: FSM=IDLE, pointers=0, `count`=0, `empty`=1, `full`=0, `dout`=8'h00, `dout_vld`=0, `ready_rst`=0, `overflow`=0. Memory contents are don't-care.
- Reset mid-handshake abandons the ack. If `rx_ready` is still high after `rst_n` deasserts, it is treated as a new byte on the first sampling edge.
- Write path: `rx_ready` is sampled high at edge N.
  - After edge N: `count` is updated and `ready_rst`=1.
  - After edge N+1: `ready_rst`=0.
  - The earliest next write is the edge after `rx_ready` is seen low in WAIT.
- Read path: `rd_en` is sampled at edge M.
  - `dout`/`dout_vld` are valid after edge M (latency 1).
  - `dout_vld` falls after edge M+1 unless another read is accepted.
- Back-to-back reads, one per cycle, are supported.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single byte: `rx_dat`=8'h34 with `rx_ready` held until `ready_rst`. Required: exactly one `ready_rst` pulse, then `count`=1 and `empty`=0. A subsequent `rd_en` pulse gives `dout`=8'h34 with `dout_vld` for one cycle, then `count`=0 and `empty`=1.
- Fill and wrap: write 8'h00..8'h0F. Required: `full`=1 and `count`=16. Read 8 bytes, then write 8'h10..8'h17. Reading all 16 must return 8'h08..8'h17 in order, exercising pointer wrap.
- Overflow: while full, receive 8'hAA. Required: `ready_rst` still pulses, `count` stays 16, `overflow`=1, and 8'hAA never appears on `dout`. Pulsing `ovf_clr` then gives `overflow`=0.
- Simultaneous: while full, `rx_ready` rises on the same edge as `rd_en`. Required: the write is accepted, `count` stays 16, and the oldest byte appears on `dout`. Repeating this with `count`=3 leaves `count`=3.
- Empty read: `rd_en`=1 for 3 cycles with the FIFO empty. Required: no `dout_vld`, `dout` unchanged, `count`=0.
- Reset mid-op: with `count`=5 and the FSM in ACK, pull `rst_n` low asynchronously. Required: all outputs go to their reset values immediately. Releasing `rst_n` with `rx_ready`=1 and `rx_dat`=8'h59 gives `count`=1, one `ready_rst` pulse, and a subsequent read returns 8'h59.
